input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive clock cycles a synchronised input must differ from its stable value before the change is accepted (10 ms at 50 MHz); legal range is 2 or more.
REQ-002 Parameter SYNC_STAGES, default 2, is the flip-flop depth of each input synchroniser; legal range is 2 or more.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 switch_raw  input  8  asynchronous slide-switch levels; 1 = on.
REQ-006 key_raw  input  2  asynchronous push-button levels; 1 = pressed.
REQ-007 switch  output  8  debounced switch levels; feeds the downstream display/LED stage unchanged.
REQ-008 key  output  2  debounced key levels.
REQ-009 key_pulse  output  2  one-cycle strobe per accepted press.
REQ-010 key_toggle  output  2  mode bit per key; inverts on each accepted press.

Function
REQ-011 The block SHALL treat all 10 inputs as independent channels, each with its own SYNC_STAGES-deep synchroniser, stable register and counter.
REQ-012 Each counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and SHALL never wrap.
REQ-013 Per channel, per cycle:
 - synced == stable -> counter cleared to 0.
 - synced != stable and counter < DEBOUNCE_CYCLES-1 -> counter incremented.
 - synced != stable and counter == DEBOUNCE_CYCLES-1 -> stable <= synced, counter <= 0.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL clear the counter on its return and SHALL NOT change the stable value.
REQ-015 Latency: after a clean raw transition, the stable output changes on the (SYNC_STAGES + DEBOUNCE_CYCLES)th rising edge after the raw change is first sampled.
REQ-016 key_pulse[i] SHALL be 1 for exactly the one cycle following the edge on which key[i] goes 0->1; it SHALL be 0 at all other times, including on release.
REQ-017 key_toggle[i] SHALL invert on the same edge on which key[i] goes 0->1, and SHALL hold otherwise.
REQ-018 Simultaneous acceptance on both keys SHALL produce both pulses in the same cycle and both toggles flipping.
REQ-019 A key held indefinitely SHALL produce exactly one pulse (no auto-repeat).
REQ-020 All outputs SHALL be registered; the block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-021 While reset is high on a clock edge, the following SHALL be cleared to 0: all synchroniser flip-flops, stable registers, counters, switch, key, key_pulse and key_toggle.
REQ-022 Reset asserted mid-debounce SHALL abandon the pending change; after release, an input still held at 1 SHALL be re-debounced from counter 0 and then produce a press pulse.
REQ-023 The block SHALL require no initial-value dependence beyond the reset of REQ-021.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-024 Scenario: reset 2 cycles, all inputs 0 -> every output 0 on the first cycle after release.
REQ-025 Scenario: key_raw=2'b10 held -> key=2'b10 on the 6th edge; key_pulse=2'b10 for exactly 1 cycle; key_toggle=2'b10. Then release -> key=2'b00 6 edges later, with no pulse.
REQ-026 Scenario: key_raw[0] high for 3 cycles, then low -> key, key_pulse and key_toggle all stay 0.
REQ-027 Scenario: switch_raw stepped 0x00..0xFF, each value held 10 cycles -> switch equals each value 6 edges after it is applied; no intermediate values appear.
REQ-028 Scenario: key_raw=2'b11 held, then reset pulsed at counter=2 -> outputs 0 during reset; after release, key=2'b11 on the 6th edge, one pulse 2'b11, key_toggle=2'b11.
REQ-029 Scenario: press key[0] three times with clean 10-cycle press/release gaps -> 3 pulses; key_toggle[0] sequence 1,0,1.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces 8 switches and 2 keys, with press strobes and toggles per key
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] switch_raw,
  input  logic [1:0] key_raw,
  output logic [7:0] switch,
  output logic [1:0] key,
  output logic [1:0] key_pulse,
  output logic [1:0] key_toggle
);
  localparam int Channels = 10;
  localparam int CountWidth = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CountWidth-1:0] CountLast = CountWidth'(DEBOUNCE_CYCLES - 1);
  logic [Channels-1:0] rawIn;
  logic [Channels-1:0] stable;
  logic [Channels-1:0] flip;
  logic [1:0] accept;
  assign rawIn = {key_raw, switch_raw};
  for (genvar c = 0; c < Channels; c++) begin : chan
    logic [SYNC_STAGES-1:0] syncChain;
    logic [CountWidth-1:0] count;
    logic synced;
    assign synced = syncChain[SYNC_STAGES-1];
    assign flip[c] = (synced != stable[c]) && (count == CountLast);
    // Shift the raw level through the synchroniser and count consecutive cycles of disagreement
    always_ff @(posedge clk)
      if (reset) begin
        syncChain <= '0;
        count <= '0;
      end else begin
        syncChain <= {syncChain[SYNC_STAGES-2:0], rawIn[c]};
        count <= (synced == stable[c] || count == CountLast) ? '0 : count + 1'b1;
      end
  end
  assign accept = flip[9:8] & ~stable[9:8];
  // Accept a channel's new level once it has disagreed for the full debounce window
  always_ff @(posedge clk)
    if (reset) stable <= '0;
    else stable <= stable ^ flip;
  // Press strobe and mode toggle fire on the same edge a key is accepted as pressed
  always_ff @(posedge clk)
    if (reset) begin
      key_pulse <= '0;
      key_toggle <= '0;
    end else begin
      key_pulse <= accept;
      key_toggle <= key_toggle ^ accept;
    end
  assign switch = stable[7:0];
  assign key = stable[9:8];
endmodule
